bcd_field_renderer: RTL and testbench

- Parametrised pixel-to-glyph engine for the VGA clock/date overlay.
- Holds a runtime table of up to N_FIELDS two-digit BCD fields. Each field has its own position, colour, scale and enable.
- Per pixel it issues the font ROM address and returns a pipelined pixel_on plus colour, aligned to pixelx/pixely by a fixed latency.
- Adds field blinking for time-set edit mode and 1x/2x glyph scaling.

---
 rtl/bcd_render_pkg.sv | 22 ++
 rtl/field_hit_unit.sv | 38 +++
 rtl/bcd_field_renderer.sv | 192 +++++++++++++++++++
 tb/tb_bcd_field_renderer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_render_pkg.sv
// rtl/bcd_render_pkg.sv - shared font geometry, character codes and field table entry type
package bcd_render_pkg;

  localparam int FONT_W = 8;
  localparam int FONT_H = 16;

  localparam logic [6:0] CHAR_ZERO  = 7'h30;
  localparam logic [6:0] CHAR_BLANK = 7'h00;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] color;
    logic       scale;
    logic       en;
  } field_cfg_t;

  function automatic logic [6:0] bcd_char(input logic [3:0] d);
    return (d > 4'd9) ? CHAR_BLANK : (CHAR_ZERO + {3'b000, d});
  endfunction

endpackage

// File: rtl/field_hit_unit.sv
// rtl/field_hit_unit.sv - box hit test and glyph-local offsets for one two-digit field
module field_hit_unit
  import bcd_render_pkg::*;
(
  input  logic [9:0]  pixelx,
  input  logic [9:0]  pixely,
  input  field_cfg_t  cfg,
  output logic        hit,
  output logic        digit,
  output logic [2:0]  column,
  output logic [3:0]  row
);

  logic [10:0] box_w;
  logic [10:0] box_h;
  logic [4:0]  dx;
  logic [4:0]  dy;
  logic [3:0]  dx_s;
  logic [3:0]  dy_s;

  always_comb begin
    box_w = 11'(2 * FONT_W) << cfg.scale;
    box_h = 11'(FONT_H) << cfg.scale;
    // 11-bit compare so a box ending past 1023 cannot wrap around to column 0
    hit = cfg.en &&
          ({1'b0, pixelx} >= {1'b0, cfg.x}) && ({1'b0, pixelx} < ({1'b0, cfg.x} + box_w)) &&
          ({1'b0, pixely} >= {1'b0, cfg.y}) && ({1'b0, pixely} < ({1'b0, cfg.y} + box_h));
    // only the low offset bits matter, and modular subtraction keeps them exact
    dx     = pixelx[4:0] - cfg.x[4:0];
    dy     = pixely[4:0] - cfg.y[4:0];
    dx_s   = cfg.scale ? dx[4:1] : dx[3:0];
    dy_s   = cfg.scale ? dy[4:1] : dy[3:0];
    digit  = dx_s[3];
    column = dx_s[2:0];
    row    = dy_s;
  end

endmodule

// File: rtl/bcd_field_renderer.sv
// rtl/bcd_field_renderer.sv - pixel-to-glyph engine for a table of two-digit BCD fields
// LEADING_ZERO_BLANK_EN: when defined, a tens digit of 0 renders blank
module bcd_field_renderer
  import bcd_render_pkg::*;
#(
  parameter int  N_FIELDS  = 8,
  parameter int  ROM_LAT   = 1,
  parameter int  BLINK_DIV = 30,
  localparam int IDX_W     = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            pixelx,
  input  logic [9:0]            pixely,
  input  logic                  frame_tick,
  input  logic [8*N_FIELDS-1:0] field_bcd,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [9:0]            cfg_x,
  input  logic [9:0]            cfg_y,
  input  logic [3:0]            cfg_color,
  input  logic                  cfg_scale,
  input  logic                  cfg_en,
  input  logic                  edit_en,
  input  logic [IDX_W-1:0]      edit_sel,
  output logic [10:0]           rom_addr,
  input  logic [7:0]            rom_data,
  output logic                  pixel_on,
  output logic [3:0]            color_addr,
  output logic                  dp
);

  field_cfg_t table_q [N_FIELDS];
  field_cfg_t table_d [N_FIELDS];

  always_comb begin
    for (int i = 0; i < N_FIELDS; i++) begin
      table_d[i] = table_q[i];
      if (cfg_we && (cfg_idx == IDX_W'(i)))
        table_d[i] = '{x: cfg_x, y: cfg_y, color: cfg_color, scale: cfg_scale, en: cfg_en};
    end
  end

  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_tick) begin
      if (blink_cnt_q == 8'(BLINK_DIV - 1)) begin
        blink_cnt_d   = 8'd0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  logic [N_FIELDS-1:0] hit_vec;
  logic [N_FIELDS-1:0] digit_vec;
  logic [2:0]          col_arr [N_FIELDS];
  logic [3:0]          row_arr [N_FIELDS];

  for (genvar gi = 0; gi < N_FIELDS; gi++) begin : g_hit
    field_hit_unit u_hit (
      .pixelx (pixelx),
      .pixely (pixely),
      .cfg    (table_q[gi]),
      .hit    (hit_vec[gi]),
      .digit  (digit_vec[gi]),
      .column (col_arr[gi]),
      .row    (row_arr[gi])
    );
  end

  logic       sel_hit, sel_digit, sel_blink;
  logic [2:0] sel_col;
  logic [3:0] sel_row, sel_color, sel_tens, sel_ones;
  logic [6:0] char_code;

  logic        s0_dp_q, s0_dp_d;
  logic [3:0]  s0_color_q, s0_color_d;
  logic [2:0]  s0_col_q, s0_col_d;
  logic [10:0] s0_addr_q, s0_addr_d;

  always_comb begin
    sel_hit   = 1'b0;
    sel_digit = 1'b0;
    sel_blink = 1'b0;
    sel_col   = 3'd0;
    sel_row   = 4'd0;
    sel_color = 4'd0;
    sel_tens  = 4'd0;
    sel_ones  = 4'd0;
    // walk downwards so the lowest-index hit is the one left standing
    for (int i = N_FIELDS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_hit   = 1'b1;
        sel_digit = digit_vec[i];
        sel_col   = col_arr[i];
        sel_row   = row_arr[i];
        sel_color = table_q[i].color;
        sel_tens  = field_bcd[8*i+4 +: 4];
        sel_ones  = field_bcd[8*i +: 4];
        sel_blink = edit_en && blink_phase_q && (edit_sel == IDX_W'(i));
      end
    end
    char_code = bcd_char(sel_digit ? sel_ones : sel_tens);
`ifdef LEADING_ZERO_BLANK_EN
    if (!sel_digit && (sel_tens == 4'd0))
      char_code = CHAR_BLANK;
`endif
    if (sel_blink || !sel_hit)
      char_code = CHAR_BLANK;
    s0_addr_d  = sel_hit ? {char_code, sel_row} : 11'd0;
    s0_dp_d    = sel_hit;
    s0_color_d = sel_color;
    s0_col_d   = sel_col;
  end

  logic        dp_pipe_q    [ROM_LAT+1];
  logic        dp_pipe_d    [ROM_LAT+1];
  logic [3:0]  color_pipe_q [ROM_LAT+1];
  logic [3:0]  color_pipe_d [ROM_LAT+1];
  logic [2:0]  col_pipe_q   [ROM_LAT+1];
  logic [2:0]  col_pipe_d   [ROM_LAT+1];
  logic [10:0] rom_addr_q, rom_addr_d;
  logic        pixel_on_q, pixel_on_d;
  logic [3:0]  color_addr_q, color_addr_d;
  logic        dp_q, dp_d;

  // side-band pipeline tracks the S1 address register plus the ROM read latency
  always_comb begin
    dp_pipe_d[0]    = s0_dp_q;
    color_pipe_d[0] = s0_color_q;
    col_pipe_d[0]   = s0_col_q;
    for (int k = 1; k <= ROM_LAT; k++) begin
      dp_pipe_d[k]    = dp_pipe_q[k-1];
      color_pipe_d[k] = color_pipe_q[k-1];
      col_pipe_d[k]   = col_pipe_q[k-1];
    end
    rom_addr_d   = s0_addr_q;
    pixel_on_d   = dp_pipe_q[ROM_LAT] & rom_data[3'd7 - col_pipe_q[ROM_LAT]];
    color_addr_d = dp_pipe_q[ROM_LAT] ? color_pipe_q[ROM_LAT] : 4'd0;
    dp_d         = dp_pipe_q[ROM_LAT];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_FIELDS; i++) table_q[i] <= '0;
      blink_cnt_q   <= 8'd0;
      blink_phase_q <= 1'b0;
      s0_dp_q       <= 1'b0;
      s0_color_q    <= 4'd0;
      s0_col_q      <= 3'd0;
      s0_addr_q     <= 11'd0;
      for (int k = 0; k <= ROM_LAT; k++) begin
        dp_pipe_q[k]    <= 1'b0;
        color_pipe_q[k] <= 4'd0;
        col_pipe_q[k]   <= 3'd0;
      end
      rom_addr_q   <= 11'd0;
      pixel_on_q   <= 1'b0;
      color_addr_q <= 4'd0;
      dp_q         <= 1'b0;
    end else begin
      for (int i = 0; i < N_FIELDS; i++) table_q[i] <= table_d[i];
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      s0_dp_q       <= s0_dp_d;
      s0_color_q    <= s0_color_d;
      s0_col_q      <= s0_col_d;
      s0_addr_q     <= s0_addr_d;
      for (int k = 0; k <= ROM_LAT; k++) begin
        dp_pipe_q[k]    <= dp_pipe_d[k];
        color_pipe_q[k] <= color_pipe_d[k];
        col_pipe_q[k]   <= col_pipe_d[k];
      end
      rom_addr_q   <= rom_addr_d;
      pixel_on_q   <= pixel_on_d;
      color_addr_q <= color_addr_d;
      dp_q         <= dp_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign pixel_on   = pixel_on_q;
  assign color_addr = color_addr_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_bcd_field_renderer.sv
// tb/tb_bcd_field_renderer.sv - scoreboard bench with a behavioural field/font model
module tb_bcd_field_renderer;
  import bcd_render_pkg::*;

  localparam int N    = 6;
  localparam int LAT  = 1;
  localparam int BDIV = 2;
  localparam int IW   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    pixelx, pixely;
  logic          frame_tick;
  logic [8*N-1:0] field_bcd;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [9:0]    cfg_x, cfg_y;
  logic [3:0]    cfg_color;
  logic          cfg_scale, cfg_en;
  logic          edit_en;
  logic [IW-1:0] edit_sel;
  logic [10:0]   rom_addr;
  logic [7:0]    rom_data;
  logic          pixel_on;
  logic [3:0]    color_addr;
  logic          dp;

  always #5 clk = ~clk;

  bcd_field_renderer #(.N_FIELDS(N), .ROM_LAT(LAT), .BLINK_DIV(BDIV)) dut (
    .clk(clk), .reset(reset), .pixelx(pixelx), .pixely(pixely), .frame_tick(frame_tick),
    .field_bcd(field_bcd), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_color(cfg_color), .cfg_scale(cfg_scale), .cfg_en(cfg_en), .edit_en(edit_en),
    .edit_sel(edit_sel), .rom_addr(rom_addr), .rom_data(rom_data), .pixel_on(pixel_on),
    .color_addr(color_addr), .dp(dp)
  );

  function automatic logic [7:0] rom_fn(input int a);
    return 8'((a * 37) ^ (a >> 3));
  endfunction

  logic [7:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_fn(int'(rom_addr));
    for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_data = rom_pipe[LAT-1];

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct { int due; logic pon; logic [3:0] col; logic dp; } exp_out_t;
  typedef struct { int due; logic [10:0] addr; } exp_rom_t;
  exp_out_t oq[$];
  exp_rom_t rq[$];

  int checks = 0;
  int errors = 0;

  int m_x[N], m_y[N], m_color[N], m_sc[N], m_en[N];
  int ticks;

  task automatic model(input int px, input int py, output logic [10:0] addr,
                       output logic pon, output logic [3:0] col, output logic dpo);
    int w, dx, dy, nib, ch, tens, ones;
    logic [7:0] b, rb;
    bit found;
    addr = 0; pon = 0; col = 0; dpo = 0; found = 0;
    for (int i = 0; i < N; i++) begin
      w = 16 << m_sc[i];
      if (!found && m_en[i] != 0 && px >= m_x[i] && px < m_x[i] + w &&
          py >= m_y[i] && py < m_y[i] + w) begin
        found = 1;
        dx = (px - m_x[i]) >> m_sc[i];
        dy = (py - m_y[i]) >> m_sc[i];
        b = field_bcd[8*i +: 8];
        tens = int'(b[7:4]);
        ones = int'(b[3:0]);
        nib = (dx >= 8) ? ones : tens;
        ch = (nib <= 9) ? 48 + nib : 0;
`ifdef LEADING_ZERO_BLANK_EN
        if (dx < 8 && tens == 0) ch = 0;
`endif
        if (edit_en && int'(edit_sel) == i && ((ticks / BDIV) % 2) == 1) ch = 0;
        addr = 11'(ch * 16 + dy);
        rb = rom_fn(ch * 16 + dy);
        pon = rb[7 - (dx % 8)];
        col = 4'(m_color[i]);
        dpo = 1;
      end
    end
  endtask

  task automatic step();
    int s;
    exp_out_t eo;
    exp_rom_t er;
    s = edge_n + 1;
    model(int'(pixelx), int'(pixely), er.addr, eo.pon, eo.col, eo.dp);
    if (reset) begin
      foreach (oq[k]) if (oq[k].due >= s) begin oq[k].pon = 0; oq[k].col = 0; oq[k].dp = 0; end
      foreach (rq[k]) if (rq[k].due >= s) rq[k].addr = 0;
      er.addr = 0; eo.pon = 0; eo.col = 0; eo.dp = 0;
    end
    er.due = s + 1;
    eo.due = s + LAT + 2;
    rq.push_back(er);
    oq.push_back(eo);
    if (reset) begin
      for (int i = 0; i < N; i++) begin m_x[i] = 0; m_y[i] = 0; m_color[i] = 0; m_sc[i] = 0; m_en[i] = 0; end
      ticks = 0;
    end else begin
      if (cfg_we && int'(cfg_idx) < N) begin
        m_x[cfg_idx] = int'(cfg_x); m_y[cfg_idx] = int'(cfg_y);
        m_color[cfg_idx] = int'(cfg_color); m_sc[cfg_idx] = int'(cfg_scale); m_en[cfg_idx] = int'(cfg_en);
      end
      if (frame_tick) ticks++;
    end
    @(posedge clk);
    #1;
    cfg_we = 0;
    frame_tick = 0;
  endtask

  always @(negedge clk) begin
    exp_rom_t er;
    exp_out_t eo;
    while (rq.size() > 0 && rq[0].due <= edge_n) begin
      er = rq.pop_front();
      checks++;
      if (er.due != edge_n || rom_addr !== er.addr) begin
        errors++;
        $display("FAIL rom_addr cyc=%0d got=%h exp=%h", edge_n, rom_addr, er.addr);
      end
    end
    while (oq.size() > 0 && oq[0].due <= edge_n) begin
      eo = oq.pop_front();
      checks++;
      if (eo.due != edge_n || pixel_on !== eo.pon || color_addr !== eo.col || dp !== eo.dp) begin
        errors++;
        $display("FAIL outputs cyc=%0d got pon=%b color=%0d dp=%b exp pon=%b color=%0d dp=%b",
                 edge_n, pixel_on, color_addr, dp, eo.pon, eo.col, eo.dp);
      end
    end
  end

  task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wr(input int idx, input int x, input int y, input int c, input int sc, input int en);
    cfg_idx = IW'(idx); cfg_x = 10'(x); cfg_y = 10'(y);
    cfg_color = 4'(c); cfg_scale = sc[0]; cfg_en = en[0]; cfg_we = 1;
    step();
  endtask

  task automatic scan(input int y, input int x0, input int x1);
    pixely = 10'(y);
    for (int x = x0; x <= x1; x++) begin
      pixelx = 10'(x);
      step();
    end
  endtask

  task automatic do_reset();
    reset = 1; step(); step(); reset = 0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin frame_tick = 1; step(); end
  endtask

  task automatic probe(input string name, input int x, input int y, input logic [10:0] exp);
    pixelx = 10'(x); pixely = 10'(y); step();
    pixelx = 10'(x + 1); step();
    chk(name, rom_addr, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", edge_n);
    $fatal(1, "timeout");
  end

  initial begin
    int j;
    logic [10:0] exp_lz;
    reset = 1; pixelx = 0; pixely = 0; frame_tick = 0; cfg_we = 0; cfg_idx = 0;
    cfg_x = 0; cfg_y = 0; cfg_color = 0; cfg_scale = 0; cfg_en = 0; edit_en = 0; edit_sel = 0;
    field_bcd = 48'h82_60_19_A3_07_45;
    ticks = 0;
    for (int i = 0; i < N; i++) begin m_x[i] = 0; m_y[i] = 0; m_color[i] = 0; m_sc[i] = 0; m_en[i] = 0; end
    repeat (3) step();
    reset = 0;
    scan(0, 0, 4);

    wr(0, 295, 240, 2, 0, 1);
    probe("tens_addr", 295, 241, 11'h341);
    probe("ones_addr", 303, 241, 11'h351);
    for (int y = 239; y <= 241; y++) scan(y, 290, 315);
    scan(255, 293, 312);
    scan(256, 293, 312);

    wr(0, 295, 240, 2, 1, 1);
    probe("scale_row", 297, 242, 11'h341);
    probe("scale_ones", 311, 243, 11'h351);
    scan(242, 292, 330);
    scan(271, 292, 330);
    scan(272, 292, 330);

    wr(3, 295, 240, 5, 1, 1);
    scan(250, 290, 300);
    wr(0, 295, 240, 2, 1, 0);
    scan(250, 290, 300);

    do_reset();
    wr(2, 100, 10, 4, 0, 1);
    probe("bad_tens", 100, 10, 11'h000);
    wr(1, 200, 10, 3, 0, 1);
`ifdef LEADING_ZERO_BLANK_EN
    exp_lz = 11'h000;
`else
    exp_lz = 11'h300;
`endif
    probe("zero_tens", 200, 10, exp_lz);
    wr(4, 1020, 20, 6, 0, 1);
    scan(25, 1010, 1023);
    scan(25, 0, 8);
    wr(6, 0, 0, 7, 0, 1);
    wr(7, 0, 0, 7, 0, 1);
    scan(3, 0, 20);

    do_reset();
    wr(0, 295, 240, 2, 0, 1);
    wr(1, 330, 240, 3, 0, 1);
    edit_en = 1; edit_sel = 0;
    tick(2);
    probe("blink_blank", 295, 245, 11'h005);
    scan(245, 290, 350);
    tick(2);
    probe("blink_show", 295, 245, 11'h345);
    scan(245, 290, 350);
    tick(2);
    edit_en = 0;
    probe("blink_off", 295, 245, 11'h345);
    scan(245, 290, 300);

    scan(246, 290, 300);
    reset = 1; pixelx = 301; step(); reset = 0;
    chk("rst_rom", rom_addr, 11'h000);
    chk("rst_out", 11'({pixel_on, dp, color_addr}), 11'h000);
    scan(246, 302, 320);
    wr(0, 295, 240, 2, 0, 1);
    scan(246, 293, 315);

    do_reset();
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 99) < 4) begin
        cfg_we = 1; cfg_idx = IW'($urandom_range(0, 7));
        cfg_x = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 1023));
        cfg_y = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 1023));
        cfg_color = 4'($urandom_range(0, 15)); cfg_scale = 1'($urandom_range(0, 1));
        cfg_en = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 99) < 8) frame_tick = 1;
      if ($urandom_range(0, 99) < 2) edit_en = ~edit_en;
      if ($urandom_range(0, 99) < 2) edit_sel = IW'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 2) field_bcd[8*$urandom_range(0, N-1) +: 8] = 8'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      j = $urandom_range(0, N - 1);
      pixelx = 10'((m_x[j] + int'($urandom_range(0, 40)) - 4) & 1023);
      pixely = 10'((m_y[j] + int'($urandom_range(0, 40)) - 4) & 1023);
      step();
    end
    reset = 0;

    for (int w = 0; w < 20 && (oq.size() > 0 || rq.size() > 0); w++) @(posedge clk);
    #1;
    checks++;
    if (oq.size() > 0 || rq.size() > 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", oq.size() + rq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
